// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control path: opcodes,
// FSM states and the datapath select/ALU codes driven by the controller.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RT   = 7'b0110011;
    localparam logic [6:0] OP_BT   = 7'b1100011;
    localparam logic [6:0] OP_IT   = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRPC,
        S_LUI, S_HALT
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_PASSB = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    // Coarse ALU request from the FSM; FUNC defers to func3/func7.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC  = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BT:   return IMM_B;
            OP_JAL:  return IMM_J;
            OP_LUI:  return IMM_U;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus instruction fields to ALUControl.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic [6:0] op,
    output logic [2:0] alu_control
);

    logic is_sub;

    // Only register-register instructions may select sub through func7.
    assign is_sub = (op == OP_RT) && (func7 == 7'b0100000);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_PASSB: alu_control = ALU_PASSB;
            default: begin
                case (func3)
                    3'b000:  alu_control = is_sub ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    3'b010:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer: steps each instruction through fetch/decode/execute/
// memory/writeback, stalling on mem_ready and halting on unknown opcodes.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       done
);

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RT:        state_d = S_EXECR;
                    OP_IT:        state_d = S_EXECI;
                    OP_BT:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI,
            S_JAL,
            S_JALRPC,
            S_LUI:      state_d = S_ALUWB;
            S_ALUWB,
            S_BRANCH:   state_d = S_FETCH;
            S_JALR:     state_d = S_JALRPC;
            default:    state_d = S_HALT;
        endcase
    end

    assign branch_taken = ((func3 == 3'b000) &&  Zero) ||
                          ((func3 == 3'b001) && !Zero);

    // Moore decode, except the mem_ready gate in FETCH and the branch decision.
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ImmSrc    = IMM_I;
        alu_op    = ALUOP_ADD;
        done      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = imm_src_for(op);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = imm_src_for(op);
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_MEMDATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNC;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNC;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_SUB;
                PCWrite = branch_taken;
            end
            S_JAL, S_JALRPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_LUI: begin
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
                alu_op  = ALUOP_PASSB;
            end
            S_HALT:     done = 1'b1;
            default:    done = 1'b1;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .func3       (func3),
        .func7       (func7),
        .op          (op),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its states and compares the packed control outputs every cycle.
module tb_multicycle_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] BT   = 7'b1100011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] BAD  = 7'b1111111;

    // {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, A, B, ImmSrc, ALUControl, done}
    localparam logic [17:0] FETCH_GO   = {5'b10100, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0};
    localparam logic [17:0] FETCH_WAIT = {5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0};
    localparam logic [17:0] ALUWB      = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
    localparam logic [17:0] HALTED     = {5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, done;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
    logic [17:0] observed;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .func3      (func3),
        .func7      (func7),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .done       (done)
    );

    assign observed = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, done};

    function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic irw,
                                       input logic mw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] imm, input logic [2:0] alu,
                                       input logic dn);
        return {pcw, adr, irw, mw, rw, rs, a, b, imm, alu, dn};
    endfunction

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z, input logic mr);
        op = o; func3 = f3; func7 = f7; Zero = z; mem_ready = mr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [17:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%05h expected=%05h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset: FETCH decode visible with mem_ready gating.
        rst_n = 1'b0;
        applyStimulus(7'd0, 3'd0, 7'd0, 1'b0, 1'b0);
        checkOutput("reset.fetch_wait", FETCH_WAIT);
        applyStimulus(7'd0, 3'd0, 7'd0, 1'b0, 1'b1);
        checkOutput("reset.fetch_gated", FETCH_GO);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // add then sub
        applyStimulus(RT, 3'b000, 7'b0000000, 1'b0, 1'b1);
        checkOutput("add.fetch", FETCH_GO);
        nextCycle; checkOutput("add.decode", mk(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("add.execr",  mk(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("add.aluwb", ALUWB);
        nextCycle; checkOutput("add.refetch", FETCH_GO);
        applyStimulus(RT, 3'b000, 7'b0100000, 1'b0, 1'b1);
        nextCycle; nextCycle;
        checkOutput("sub.execr", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0));
        nextCycle; checkOutput("sub.aluwb", ALUWB);
        nextCycle; checkOutput("sub.refetch", FETCH_GO);

        // I-type: func7 ignored, func3 selects and/or/slt live
        applyStimulus(IT, 3'b000, 7'b0100000, 1'b0, 1'b1);
        nextCycle; nextCycle;
        checkOutput("addi.execi", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        applyStimulus(IT, 3'b010, 7'b0, 1'b0, 1'b1);
        checkOutput("slti.execi", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b101, 0));
        applyStimulus(IT, 3'b111, 7'b0, 1'b0, 1'b1);
        checkOutput("andi.execi", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b010, 0));
        applyStimulus(IT, 3'b110, 7'b0, 1'b0, 1'b1);
        checkOutput("ori.execi", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b011, 0));
        applyStimulus(IT, 3'b001, 7'b0, 1'b0, 1'b1);
        checkOutput("f3_001.execi", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("addi.aluwb", ALUWB);
        nextCycle; checkOutput("addi.refetch", FETCH_GO);

        // lw: FETCH stall, then MEMREAD stalled two cycles
        applyStimulus(LW, 3'b010, 7'b0, 1'b0, 1'b0);
        checkOutput("lw.fetch_stall", FETCH_WAIT);
        nextCycle; checkOutput("lw.fetch_hold", FETCH_WAIT);
        applyStimulus(LW, 3'b010, 7'b0, 1'b0, 1'b1);
        checkOutput("lw.fetch_go", FETCH_GO);
        nextCycle; checkOutput("lw.decode", mk(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("lw.memadr", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        nextCycle;
        applyStimulus(LW, 3'b010, 7'b0, 1'b0, 1'b0);
        checkOutput("lw.memread0", mk(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("lw.memread1", mk(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        nextCycle;
        applyStimulus(LW, 3'b010, 7'b0, 1'b0, 1'b1);
        checkOutput("lw.memread2", mk(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("lw.memwb", mk(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("lw.refetch", FETCH_GO);

        // sw completing normally
        applyStimulus(SW, 3'b010, 7'b0, 1'b0, 1'b1);
        nextCycle; checkOutput("sw.decode", mk(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b001, 3'b000, 0));
        nextCycle; checkOutput("sw.memadr", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 0));
        nextCycle; checkOutput("sw.memwrite", mk(0,1,0,1,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("sw.refetch", FETCH_GO);

        // sw aborted by reset while MemWrite is held
        nextCycle; nextCycle; nextCycle;
        applyStimulus(SW, 3'b010, 7'b0, 1'b0, 1'b0);
        checkOutput("swrst.memwrite", mk(0,1,0,1,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("swrst.memwrite_hold", mk(0,1,0,1,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        #2; rst_n = 1'b0; #1;
        checkOutput("swrst.async_drop", FETCH_WAIT);
        applyStimulus(SW, 3'b010, 7'b0, 1'b0, 1'b1);
        checkOutput("swrst.gated", FETCH_GO);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // beq/bne decisions evaluated live in BRANCH
        applyStimulus(BT, 3'b000, 7'b0, 1'b1, 1'b1);
        nextCycle; checkOutput("beq.decode", mk(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 0));
        nextCycle; checkOutput("beq.taken", mk(1,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0));
        applyStimulus(BT, 3'b000, 7'b0, 1'b0, 1'b1);
        checkOutput("beq.not_taken", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0));
        applyStimulus(BT, 3'b001, 7'b0, 1'b0, 1'b1);
        checkOutput("bne.taken", mk(1,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0));
        applyStimulus(BT, 3'b001, 7'b0, 1'b1, 1'b1);
        checkOutput("bne.not_taken", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0));
        applyStimulus(BT, 3'b100, 7'b0, 1'b1, 1'b1);
        checkOutput("f3_100.not_taken", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 0));
        nextCycle; checkOutput("beq.refetch", FETCH_GO);

        // jal
        applyStimulus(JAL, 3'b000, 7'b0, 1'b0, 1'b1);
        nextCycle; checkOutput("jal.decode", mk(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b011, 3'b000, 0));
        nextCycle; checkOutput("jal.jal", mk(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("jal.aluwb", ALUWB);
        nextCycle; checkOutput("jal.refetch", FETCH_GO);

        // jalr
        applyStimulus(JALR, 3'b000, 7'b0, 1'b0, 1'b1);
        nextCycle; checkOutput("jalr.decode", mk(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("jalr.jalr", mk(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("jalr.jalrpc", mk(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0));
        nextCycle; checkOutput("jalr.aluwb", ALUWB);
        nextCycle; checkOutput("jalr.refetch", FETCH_GO);

        // lui
        applyStimulus(LUI, 3'b000, 7'b0, 1'b0, 1'b1);
        nextCycle; checkOutput("lui.decode", mk(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b100, 3'b000, 0));
        nextCycle; checkOutput("lui.lui", mk(0,0,0,0,0, 2'b00, 2'b00, 2'b01, 3'b100, 3'b100, 0));
        nextCycle; checkOutput("lui.aluwb", ALUWB);
        nextCycle; checkOutput("lui.refetch", FETCH_GO);

        // unknown opcode halts until reset
        applyStimulus(BAD, 3'b000, 7'b0, 1'b0, 1'b1);
        nextCycle; checkOutput("halt.decode", mk(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0));
        nextCycle;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(BAD, 3'b000, 7'b0, i[0], i[1]);
            checkOutput("halt.absorb", HALTED);
            nextCycle;
        end
        applyStimulus(BAD, 3'b000, 7'b0, 1'b0, 1'b0);
        rst_n = 1'b0; #1;
        checkOutput("halt.reset", FETCH_WAIT);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nextCycle; checkOutput("halt.after_reset", FETCH_WAIT);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the RV32I-subset core (lw, sw, R-type, I-type ALU, beq/bne, jal, jalr, lui) sharing one ALU and one unified instruction/data memory. It replaces the single-cycle control path. It holds the FSM that steps each instruction through fetch, decode, execute, memory and writeback. Each state drives the datapath mux selects and write enables. It stalls on a memory-ready handshake and halts on an unknown opcode.

## Interface
- No parameters; encodings are fixed in the shared package.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- op  in  7  IR[6:0]; func3 in 3 IR[14:12]; func7 in 7 IR[31:25]
- Zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  load PC from the result bus
- AdrSrc  out  1  memory address: 0 = PC, 1 = result bus
- IRWrite  out  1  latch IR and OldPC
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register-file write
- ResultSrc  out  2  result bus: 00 = ALUOut register, 01 = memory data register, 10 = ALU result (live)
- ALUSrcA  out  2  ALU A input: 00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  ALU B input: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- ALUControl  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 100 = pass B, 101 = slt
- done  out  1  halted

## Operation
Outputs are Moore (decoded from the state), except for two Mealy gates: PCWrite and IRWrite in FETCH, and PCWrite in BRANCH. Every output not listed for a state is 0.

- **FETCH**
  - Drives AdrSrc=0, A=00, B=10, add, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while !mem_ready; otherwise goes to DECODE.
- **DECODE**
  - Drives A=01, B=01, add. The branch/jal target lands in ALUOut.
  - ImmSrc by op: sw=001, BT=010, jal=011, lui=100, all others 000.
  - Next state by op: lw/sw → MEMADR; RT → EXECR; IT → EXECI; BT → BRANCH; jal → JAL; jalr → JALR; lui → LUI; any other op → HALT.
- **MEMADR**: A=10, B=01, ImmSrc from op, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD**: AdrSrc=1, ResultSrc=00. Waits for mem_ready, then goes to MEMWB.
- **MEMWB**: ResultSrc=01, RegWrite=1. Goes to FETCH.
- **MEMWRITE**: AdrSrc=1, ResultSrc=00. MemWrite=1 is held until mem_ready, then goes to FETCH.
- **EXECR**: A=10, B=00. ALU op from func3/func7:
  - 000 → add, or sub if func7=0100000
  - 111 → and; 110 → or; 010 → slt
  - any other func3 → add
  - Goes to ALUWB.
- **EXECI**: A=10, B=01, ImmSrc=000. ALU op as EXECR, but func7 is ignored (func3=000 is always add). Goes to ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite=1. Goes to FETCH.
- **BRANCH**: A=10, B=00, sub, ResultSrc=00. PCWrite = (func3=000 & Zero) | (func3=001 & !Zero). Any other func3 is not taken. Goes to FETCH.
- **JAL**: A=01, B=10, add, ResultSrc=00, PCWrite=1. Goes to ALUWB, which writes OldPC+4 to rd.
- **JALR**: A=10, B=01, ImmSrc=000, add (ALUOut ← rs1+imm). Goes to JALRPC.
- **JALRPC**: A=01, B=10, add, ResultSrc=00, PCWrite=1. Goes to ALUWB.
- **LUI**: B=01, ImmSrc=100, pass B. Goes to ALUWB.
- **HALT**: done=1. Absorbing state; only reset leaves it.

## Timing
- Reset drives state to FETCH. While rst_n=0, outputs show FETCH decode with mem_ready gating; done=0, MemWrite=0, RegWrite=0.
- Reset deassertion is synchronous to clk by the integrator.
- Cycles per instruction with mem_ready constantly 1:
  - lw 5; sw 4
  - R-type, I-type, lui 4
  - beq/bne 3
  - jal 4; jalr 5
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle. The memory access and its strobes are held stable throughout.
- Reset mid-instruction aborts it immediately. A pending MemWrite or RegWrite drops asynchronously.
- The rs1 read in JALR precedes the rd write in ALUWB, so jalr with rd=rs1 is correct.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - opcode localparams: lw, sw, RT, BT, IT, jalr, jal, lui
  - the state enum (4-bit)
  - ALUControl, ImmSrc, ResultSrc and ALUSrcA/B encodings
- Sub-module `alu_decoder` maps {aluOp[1:0], func3, func7, op} to ALUControl, reused from the single-cycle core's ALU mapping.
- The FSM has a state register, a next-state block and an output decode.

## Test plan
- Reset mid-MEMWRITE (MemWrite=1), rst_n→0 → MemWrite=0 asynchronously; state FETCH; done=0.
- add (op 0110011, f3 000, f7 0000000), mem_ready=1 → FETCH, DECODE, EXECR (ALUControl 000), ALUWB (RegWrite=1) → FETCH, 4 cycles. Same with f7=0100000 → ALUControl 001.
- lw with mem_ready low 2 cycles in MEMREAD → AdrSrc held 1 for 3 cycles; MEMWB asserts ResultSrc=01 and RegWrite exactly once; 7 cycles total.
- beq, Zero=1 → BRANCH PCWrite=1; Zero=0 → PCWrite=0. bne inverts this. func3=100 with Zero=1 → PCWrite=0.
- jalr → JALR (A=10, B=01), JALRPC (PCWrite=1, ResultSrc=00), ALUWB (RegWrite=1); 5 cycles.
- op=1111111 → DECODE then HALT; done=1 for 10+ cycles with all write enables 0; rst_n pulse → FETCH, done=0.
